// File: rtl/deserializer.sv
// Serial-to-parallel word assembler: MSB-first bits qualified by a valid run, left-aligned output word plus bit count.
// Optional DESERIALIZER_SHORT_DROP_EN discards words that end with only 1 or 2 bits.
module deserializer #(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic                      ser_data_i,
  input  logic                      ser_data_val_i,
  output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
  output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
  output logic                      deser_data_val_o,
  output logic                      busy_o
);

  localparam int unsigned CNT_WIDTH = DATA_MOD_WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                    state;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [DATA_BUS_WIDTH-1:0] buffer;

  logic [DATA_MOD_WIDTH-1:0] idx;
  logic [DATA_BUS_WIDTH-1:0] buf_upd;
  logic [CNT_WIDTH-1:0]      cnt_inc;
  logic                      short_word;

  // Next buffer image with the incoming bit placed at its left-aligned slot.
  always_comb begin
    idx          = DATA_MOD_WIDTH'(DATA_BUS_WIDTH - 1) - cnt[DATA_MOD_WIDTH-1:0];
    buf_upd      = buffer;
    buf_upd[idx] = ser_data_i;
    cnt_inc      = cnt + CNT_WIDTH'(1);
`ifdef DESERIALIZER_SHORT_DROP_EN
    short_word   = (cnt == CNT_WIDTH'(1)) || (cnt == CNT_WIDTH'(2));
`else
    short_word   = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      buffer           <= '0;
      deser_data_o     <= '0;
      deser_data_mod_o <= '0;
      deser_data_val_o <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      case (state)
        IDLE: begin
          if (ser_data_val_i) begin
            // First bit of a word: clear stale contents so unfilled LSBs read as zero.
            buffer <= {ser_data_i, {(DATA_BUS_WIDTH-1){1'b0}}};
            cnt    <= CNT_WIDTH'(1);
            state  <= RECV;
            busy_o <= 1'b1;
          end
        end
        RECV: begin
          if (ser_data_val_i) begin
            buffer <= buf_upd;
            cnt    <= cnt_inc;
            if (cnt_inc == CNT_WIDTH'(DATA_BUS_WIDTH)) begin
              deser_data_o     <= buf_upd;
              deser_data_mod_o <= cnt_inc[DATA_MOD_WIDTH-1:0];
              deser_data_val_o <= 1'b1;
              cnt              <= '0;
              state            <= IDLE;
              busy_o           <= 1'b0;
            end
          end else begin
            if (!short_word) begin
              deser_data_o     <= buffer;
              deser_data_mod_o <= cnt[DATA_MOD_WIDTH-1:0];
              deser_data_val_o <= 1'b1;
            end
            cnt    <= '0;
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: driver queues expected words, negedge monitor pops and checks them.
module tb_deserializer;

  logic        clk;
  logic        srst_i;
  logic        ser_data_i;
  logic        ser_data_val_i;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        busy_o;

  deserializer #(.DATA_BUS_WIDTH(16), .DATA_MOD_WIDTH(4)) dut (
    .clk_i            (clk),
    .srst_i           (srst_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o)
  );

`ifdef DESERIALIZER_SHORT_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          edge_no;
  } exp_t;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          errors    = 0;
  int          edge_n    = 0;
  int          busy_cnt  = 0;
  logic [15:0] last_data = '0;
  logic [3:0]  last_mod  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Monitor: pop on every pulse, otherwise verify outputs hold the last delivered word.
  always @(negedge clk) begin
    exp_t e;
    if (busy_o === 1'b1) busy_cnt++;
    if (deser_data_val_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(deser_data_o), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("data", 32'(deser_data_o), 32'(e.data));
        chk("mod", 32'(deser_data_mod_o), 32'(e.mod));
        chk("pulse_edge", 32'(edge_n), 32'(e.edge_no));
        last_data = e.data;
        last_mod  = e.mod;
      end
    end else if (srst_i === 1'b0) begin
      chk("hold_data", 32'(deser_data_o), 32'(last_data));
      chk("hold_mod", 32'(deser_data_mod_o), 32'(last_mod));
    end
  end

  task automatic step(input logic v, input logic d);
    ser_data_val_i = v;
    ser_data_i     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, w[15-i]);
  endtask

  // dly = number of steps until the edge that loads the outputs.
  task automatic expect_word(input logic [15:0] d, input logic [3:0] m, input int dly);
    exp_t e;
    e.data    = d;
    e.mod     = m;
    e.edge_no = edge_n + dly;
    exp_q.push_back(e);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
  endtask

  initial begin
    logic [15:0] w;
    int          len;
    srst_i         = 1'b1;
    ser_data_i     = 1'b1;
    ser_data_val_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(deser_data_o), 32'h0);
    chk("rst_mod", 32'(deser_data_mod_o), 32'h0);
    chk("rst_val", 32'(deser_data_val_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    srst_i = 1'b0;
    gap(2);

    // Full word then gap.
    expect_word(16'hA5C3, 4'd0, 16);
    send(16'hA5C3, 16);
    gap(3);

    // 5-bit word 1,0,1,1,0; busy must be high for exactly five cycles.
    busy_cnt = 0;
    expect_word(16'hB000, 4'd5, 6);
    send(16'hB000, 1);
    chk("busy_first_bit", 32'(busy_o), 32'h1);
    send(16'h6000, 4);
    gap(3);
    chk("busy_cycles", 32'(busy_cnt), 32'd5);
    chk("busy_after", 32'(busy_o), 32'h0);

    // Two back-to-back full words.
    expect_word(16'h1234, 4'd0, 16);
    expect_word(16'hFFFF, 4'd0, 32);
    send(16'h1234, 16);
    send(16'hFFFF, 16);
    gap(3);

    // 2-bit word: dropped only with the short-drop feature.
    if (!DROP) expect_word(16'hC000, 4'd2, 3);
    send(16'hC000, 2);
    gap(3);

    // 1-bit word and 3-bit word boundaries.
    if (!DROP) expect_word(16'h8000, 4'd1, 2);
    send(16'h8000, 1);
    gap(2);
    expect_word(16'hA000, 4'd3, 4);
    send(16'hA000, 3);
    gap(2);

    // W-1 bit word.
    expect_word(16'hFFFE, 4'd15, 16);
    send(16'hFFFF, 15);
    gap(2);

    // Reset after 7 of 12 bits, then a 4-bit word.
    send(16'hABC0, 7);
    srst_i = 1'b1;
    step(1'b1, 1'b1);
    last_data = '0;
    last_mod  = '0;
    chk("midrst_busy", 32'(busy_o), 32'h0);
    chk("midrst_data", 32'(deser_data_o), 32'h0);
    srst_i = 1'b0;
    expect_word(16'h9000, 4'd4, 5);
    send(16'h9000, 4);
    gap(3);

    // Random lengths and gaps, with random data while valid is low.
    for (int k = 0; k < 40; k++) begin
      len = int'($urandom_range(1, 16));
      w   = '0;
      for (int i = 0; i < len; i++) w[15-i] = 1'($urandom);
      if (len == 16) expect_word(w, 4'd0, 16);
      else if (!(DROP && len <= 2)) expect_word(w, 4'(len), len + 1);
      send(w, len);
      if (len == 16) gap(int'($urandom_range(0, 2)));
      else gap(int'($urandom_range(1, 3)));
    end
    gap(4);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, edge %0d", edge_n);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter DATA_BUS_WIDTH, default 16, giving the parallel output width in bits.
REQ-002 The block SHALL have parameter DATA_MOD_WIDTH, default 4, giving the bit-count output width; DATA_BUS_WIDTH SHALL equal 2**DATA_MOD_WIDTH.
REQ-003 clk_i  input  1  single clock; all logic on posedge.
REQ-004 srst_i  input  1  reset, synchronous, active-high.
REQ-005 ser_data_i  input  1  serial data bit, MSB first; sampled only when ser_data_val_i=1.
REQ-006 ser_data_val_i  input  1  serial bit valid; a contiguous run of 1s forms one word.
REQ-007 deser_data_o  output  DATA_BUS_WIDTH  assembled word, left-aligned, unfilled LSBs zero.
REQ-008 deser_data_mod_o  output  DATA_MOD_WIDTH  bit count of the word; 0 means DATA_BUS_WIDTH bits.
REQ-009 deser_data_val_o  output  1  one-cycle pulse; qualifies deser_data_o and deser_data_mod_o.
REQ-010 busy_o  output  1  high while a partial word is held (state RECV).

Function
REQ-011 FSM states SHALL be IDLE and RECV.
- IDLE->RECV on a sampled ser_data_val_i=1.
- RECV->IDLE on a sampled ser_data_val_i=0, or when the DATA_BUS_WIDTH-th bit is sampled.
REQ-012 The k-th sampled bit of a word (k=0 first) SHALL be written to shift-buffer position DATA_BUS_WIDTH-1-k; the bit counter SHALL be cleared at word start.
REQ-013 Gap termination: on the edge sampling ser_data_val_i=0 in RECV with count n (1..DATA_BUS_WIDTH-1), the outputs SHALL load buffer and n, with deser_data_val_o=1 in the following cycle.
REQ-014 Full termination: on the edge sampling the DATA_BUS_WIDTH-th bit, the outputs SHALL load buffer and mod=0, with deser_data_val_o=1 in the following cycle; no gap is needed.
REQ-015 Back-to-back: a valid bit sampled on the cycle after full termination SHALL start a new word as bit 0 with no lost bits, while the previous word's pulse is on the outputs.
REQ-016 deser_data_val_o SHALL be high for exactly one cycle per word; deser_data_o and deser_data_mod_o SHALL hold their last value until the next word loads.
REQ-017 busy_o SHALL equal (state==RECV), registered, with no combinational path from the inputs.
REQ-018 The bit counter SHALL be DATA_MOD_WIDTH+1 bits wide internally; deser_data_mod_o SHALL be count modulo DATA_BUS_WIDTH.
REQ-019 ser_data_i SHALL be ignored whenever ser_data_val_i=0.
REQ-020 The block SHALL have no backpressure: a downstream stage that does not capture the pulse loses the word.

Reset
REQ-021 While srst_i=1: state=IDLE, counter=0, buffer=0, deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0.
REQ-022 Reset mid-word SHALL discard the partial word with no pulse; the first valid bit sampled after srst_i deasserts SHALL be bit 0 of a new word.
REQ-023 srst_i SHALL take priority over all other events in the same cycle.

Configuration
REQ-024 The macro DESERIALIZER_SHORT_DROP_EN SHALL control handling of short words.
- Defined: words terminating with count 1 or 2 SHALL be discarded (no pulse, outputs unchanged, FSM returns to IDLE), matching the upstream serializer, which never emits 1- or 2-bit transactions.
- Undefined: words of every length 1..DATA_BUS_WIDTH SHALL be delivered per REQ-013/014.

Verification
REQ-025 16 valid bits 0xA5C3, then val=0 -> one pulse, data=0xA5C3, mod=0, one cycle after the 16th bit.
REQ-026 5 bits 1,0,1,1,0, then val=0 -> pulse one cycle after the low sample, data=0xB000, mod=5; busy_o high for exactly 5 cycles.
REQ-027 32 contiguous valid bits 0x1234 then 0xFFFF -> two pulses 16 cycles apart, data 0x1234 then 0xFFFF, mod=0 both.
REQ-028 2 bits 1,1, then val=0 -> macro defined: no pulse, outputs unchanged; macro undefined: data=0xC000, mod=2.
REQ-029 srst_i=1 after 7 of 12 bits, then a 4-bit word 1,0,0,1 -> no pulse for the aborted word; next pulse data=0x9000, mod=4.
REQ-030 Random val gaps with random ser_data_i while val=0 -> the scoreboard matches every word; ignored ser_data_i values never appear in the output.
